// File: rtl/booth_pkg.sv
// Shared definitions for the sequential radix-4 Booth multiplier.
//
// Contents:
//   state_t          - control FSM states (idle, run, done)
//   CODE_*           - bit positions inside the 5-bit one-hot encoder code
//   SEL_*            - the matching one-hot code values, for case decoding
//   booth_code_len() - width of the encoder code
package booth_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_t;

  localparam int unsigned CodeW = 5;

  // Bit positions of the one-hot partial-product select code.
  localparam int unsigned CODE_0X  = 4;
  localparam int unsigned CODE_P2X = 3;
  localparam int unsigned CODE_N2X = 2;
  localparam int unsigned CODE_P1X = 1;
  localparam int unsigned CODE_N1X = 0;

  // Full code values with exactly one bit set.
  localparam logic [CodeW-1:0] SEL_0X  = 5'b00001 << CODE_0X;
  localparam logic [CodeW-1:0] SEL_P2X = 5'b00001 << CODE_P2X;
  localparam logic [CodeW-1:0] SEL_N2X = 5'b00001 << CODE_N2X;
  localparam logic [CodeW-1:0] SEL_P1X = 5'b00001 << CODE_P1X;
  localparam logic [CodeW-1:0] SEL_N1X = 5'b00001 << CODE_N1X;

  function automatic int unsigned booth_code_len();
    return CodeW;
  endfunction

endpackage

// File: rtl/booth_seq_ctrl_encoder.sv
// Radix-4 Booth encoder for one 3-bit multiplier window.
//
// Ports:
//   window - {y[2i+1], y[2i], y[2i-1]} for the current step
//   code   - one-hot select: bit4 0, bit3 +2X, bit2 -2X, bit1 +X, bit0 -X
module booth_seq_ctrl_encoder
  import booth_pkg::*;
(
  input  logic [2:0]       window,
  output logic [CodeW-1:0] code
);

  always_comb begin
    code = '0;
    unique case (window)
      3'b000, 3'b111: code[CODE_0X]  = 1'b1;
      3'b001, 3'b010: code[CODE_P1X] = 1'b1;
      3'b011:         code[CODE_P2X] = 1'b1;
      3'b100:         code[CODE_N2X] = 1'b1;
      3'b101, 3'b110: code[CODE_N1X] = 1'b1;
      default:        code = '0;
    endcase
  end

endmodule

// File: rtl/booth_seq_ctrl.sv
// Sequential signed multiplier using radix-4 Booth recoding, one window per cycle.
//
// Ports:
//   clk, rst      - clock and synchronous active-high reset
//   in_valid      - operand pair is valid
//   in_ready      - block accepts operands (idle only)
//   multiplicand  - signed X, WIDTH bits
//   multiplier    - signed Y, WIDTH bits
//   out_valid     - product is valid (done only)
//   out_ready     - consumer accepts the product
//   product       - signed X*Y, 2*WIDTH bits; held after the handshake
//   busy          - a computation is running or waiting to be taken
//
// An accept moves to RUN for WIDTH/2 cycles, then DONE until out_ready.
// WIDTH must be even and at least 4.
module booth_seq_ctrl
  import booth_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  localparam int unsigned PW    = 2 * WIDTH;
  localparam int unsigned Steps = WIDTH / 2;
  localparam int unsigned CntW  = (Steps > 1) ? $clog2(Steps) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(Steps - 1);

  state_t           state_q;
  logic [PW-1:0]    x_q;        // X pre-shifted by 2i for the current step
  logic [WIDTH:0]   y_q;        // Y with an appended 0, shifted right by 2i
  logic [PW-1:0]    acc_q;
  logic [PW-1:0]    product_q;
  logic [CntW-1:0]  cnt_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             busy_q;

  logic [CodeW-1:0] code;
  logic [PW-1:0]    pp;
  logic [PW-1:0]    acc_sum;

  // The low three bits of the shifted Y are always the current window.
  booth_seq_ctrl_encoder u_encoder (
    .window (y_q[2:0]),
    .code   (code)
  );

  // Partial-product selection; anything not exactly one-hot adds nothing.
  always_comb begin
    pp = '0;
    unique case (code)
      SEL_0X:  pp = '0;
      SEL_P2X: pp = x_q << 1;
      SEL_N2X: pp = '0 - (x_q << 1);
      SEL_P1X: pp = x_q;
      SEL_N1X: pp = '0 - x_q;
      default: pp = '0;
    endcase
  end

  // Wraps modulo 2^PW, which is exactly the two's-complement product width.
  assign acc_sum = acc_q + pp;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      x_q         <= '0;
      y_q         <= '0;
      acc_q       <= '0;
      product_q   <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid && in_ready_q) begin
            x_q         <= {{WIDTH{multiplicand[WIDTH-1]}}, multiplicand};
            y_q         <= {multiplier, 1'b0};
            acc_q       <= '0;
            cnt_q       <= '0;
            state_q     <= StRun;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b1;
          end
        end

        StRun: begin
          acc_q <= acc_sum;
          x_q   <= x_q << 2;
          y_q   <= {2'b00, y_q[WIDTH:2]};
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LastCnt) begin
            product_q   <= acc_sum;
            state_q     <= StDone;
            out_valid_q <= 1'b1;
          end
        end

        StDone: begin
          // Returning to idle here, rather than accepting, keeps the
          // output handshake and the next accept in separate cycles.
          if (out_ready) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end

        default: begin
          state_q     <= StIdle;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign product   = product_q;

endmodule

// File: doc/booth_seq_ctrl.md
BOOTH_SEQ_CTRL -- requirements
Module: booth_seq_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits; it SHALL be even and >= 4.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port in_valid, input, 1 bit: the operand pair is valid.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block accepts operands.
REQ-006 The block SHALL have port multiplicand, input, WIDTH bits: signed two's-complement X.
REQ-007 The block SHALL have port multiplier, input, WIDTH bits: signed two's-complement Y, recoded radix-4.
REQ-008 The block SHALL have port out_valid, output, 1 bit: the product is valid.
REQ-009 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the product.
REQ-010 The block SHALL have port product, output, 2*WIDTH bits: signed X*Y.
REQ-011 The block SHALL have port busy, output, 1 bit: high in RUN or DONE.

Function
REQ-012 The FSM SHALL have exactly the states IDLE, RUN and DONE.
REQ-013 in_ready SHALL be 1 only in IDLE; an accept is in_valid && in_ready at a rising edge.
REQ-014 On accept, the block SHALL latch X (sign-extended to 2*WIDTH), latch Y with an appended LSB of 0, clear the accumulator and step counter, and enter RUN.
REQ-015 In RUN step i (0..WIDTH/2-1), the block SHALL present the window {Y[2i+1], Y[2i], Y[2i-1]} to the encoder, with Y[-1]=0.
REQ-016 In the same step the block SHALL add to the accumulator the partial product selected by the encoder's one-hot code, shifted left by 2i; the sum SHALL be taken modulo 2^(2*WIDTH).
REQ-017 The one-hot code SHALL map as follows: bit4 selects 0, bit3 selects +2X, bit2 selects -2X, bit1 selects +X, bit0 selects -X.
REQ-018 An all-zero or multi-hot code SHALL contribute 0.
REQ-019 RUN SHALL last exactly WIDTH/2 cycles; after the last step the block SHALL enter DONE.
REQ-020 For an accept at edge t, out_valid SHALL first be high in the cycle following edge t+WIDTH/2.
REQ-021 In DONE, out_valid SHALL be 1 and product SHALL hold constant until out_ready is 1 at an edge; the block SHALL then return to IDLE.
REQ-022 No new accept SHALL occur in the same cycle as the output handshake; in_ready SHALL rise one cycle later.
REQ-023 product SHALL retain the last result in IDLE; out_valid SHALL be 0 outside DONE.
REQ-024 in_valid SHALL be ignored in RUN and DONE, and operand input changes SHALL NOT affect a computation in flight.

Reset
REQ-025 When rst is high at an edge, the FSM SHALL go to IDLE, and product, the accumulator and the step counter SHALL clear to 0, including mid-RUN or in DONE; the in-flight result SHALL be discarded.
REQ-026 The reset values SHALL be in_ready=1, out_valid=0, busy=0 and product=0.

Structure
REQ-027 The shared package booth_pkg SHALL hold the FSM state enum and the named bit indices of the 5-bit encoder code (CODE_0X=4, CODE_P2X=3, CODE_N2X=2, CODE_P1X=1, CODE_N1X=0).
REQ-028 The block SHALL instantiate one sub-module, the team's 3-bit-window radix-4 Booth_Encoder, which returns the 5-bit one-hot code.
REQ-029 The step counter SHALL be ceil(log2(WIDTH/2)) bits wide; the partial-product selection SHALL be combinational from the encoder code.

Verification (WIDTH=8)
REQ-030 X=-128, Y=-128, out_ready=1 SHALL give product 0x4000, with out_valid high 5 cycles after accept.
REQ-031 X=-128, Y=127 SHALL give 0xC080; X=0, Y=-1 SHALL give 0x0000; X=3, Y=5 SHALL give 0x000F.
REQ-032 With X=7, Y=-9 and out_ready held low 6 cycles, product SHALL stay 0xFFC1 with out_valid high and in_ready 0, then return to IDLE one edge after out_ready=1.
REQ-033 With rst pulsed at RUN step 2, the block SHALL be in IDLE the next cycle with product=0 and no out_valid; a fresh X=2, Y=2 SHALL give 0x0004.
REQ-034 Back-to-back operation with in_valid held high and operands changed during RUN SHALL take exactly one accept per IDLE visit, and each result SHALL match the operands latched at accept.
REQ-035 A random regression of 10k signed pairs SHALL match a reference X*Y bit-exactly.
